// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART controller: register map, bit positions,
// protocol FSM states and the decoded register-select type.
package apb_uart_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_TXDATA = 4'h4;
    localparam logic [3:0] ADDR_RXDATA = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_IRQ_RX_EN  = 2;
    localparam int CTRL_IRQ_OVR_EN = 3;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_TIMEOUT  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT
    } apb_state_t;

    typedef struct packed {
        logic status;
        logic rxdata;
        logic txdata;
        logic ctrl;
    } reg_sel_t;

endpackage

// File: rtl/apb_uart_addr_decode.sv
// Combinational register decode: one-hot select for legal accesses, an illegal
// flag for misaligned addresses and writes to the read-only RXDATA register.
module apb_uart_addr_decode
    import apb_uart_pkg::*;
(
    input  logic [3:0] paddr,
    input  logic       pwrite,
    output reg_sel_t   sel,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        sel     = '0;
        illegal = 1'b0;
        if (paddr[1:0] != 2'b00) begin
            illegal = 1'b1;
        end else begin
            case (paddr)
                ADDR_CTRL:   sel.ctrl   = 1'b1;
                ADDR_TXDATA: sel.txdata = 1'b1;
                ADDR_RXDATA: begin
                    if (pwrite) illegal    = 1'b1;
                    else        sel.rxdata = 1'b1;
                end
                ADDR_STATUS: sel.status = 1'b1;
                default:     illegal    = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 slave front end for the UART: SETUP/ACCESS sequencing with TX back-pressure
// wait states and timeout, one-entry TX/RX holding registers, CTRL/STATUS and irq.
module apb_uart_ctrl
    import apb_uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [3:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    apb_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [3:0]        ctrl;
    logic              tx_full, rx_full, overrun, timeout_err;
    logic [DATA_W-1:0] rx_hold;
    logic [DATA_W-1:0] rdata;

    reg_sel_t sel;
    logic     illegal;
    logic     tx_drain, can_load, tx_stall, timeout_hit;
    logic     wr_en, rd_en, pop, rx_in;

    apb_uart_addr_decode u_decode (
        .paddr   (PADDR),
        .pwrite  (PWRITE),
        .sel     (sel),
        .illegal (illegal)
    );

    assign tx_valid = tx_full & ctrl[CTRL_TX_EN];
    assign tx_drain = tx_valid & tx_ready;
    // A held byte only frees the register when the shifter actually takes it.
    assign can_load = ~tx_full | tx_drain;
    assign tx_stall = sel.txdata & PWRITE & ~can_load;
    assign irq      = (rx_full & ctrl[CTRL_IRQ_RX_EN]) | (overrun & ctrl[CTRL_IRQ_OVR_EN]);

    always_comb begin
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ACCESS: begin
                if (PSEL && !tx_stall) begin
                    PREADY  = 1'b1;
                    PSLVERR = illegal;
                end
            end
            WAIT: begin
                if (can_load) begin
                    PREADY = 1'b1;
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    PREADY      = 1'b1;
                    PSLVERR     = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wr_en = PREADY & ~PSLVERR & PWRITE;
    assign rd_en = PREADY & ~PSLVERR & ~PWRITE;
    assign pop   = rd_en & sel.rxdata;
    assign rx_in = rx_valid & ctrl[CTRL_RX_EN];

    always_comb begin
        rdata = '0;
        if (sel.ctrl)   rdata[3:0] = ctrl;
        if (sel.rxdata) rdata      = rx_hold;
        if (sel.status) rdata[3:0] = {timeout_err, overrun, rx_full, tx_full};
    end

    assign PRDATA = rd_en ? rdata : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) state <= ACCESS;
                end
                ACCESS: begin
                    if (PSEL && tx_stall) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (PREADY || !PSEL) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the holding registers are reset too; their contents are architecturally visible.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl        <= '0;
            tx_full     <= 1'b0;
            tx_data     <= '0;
            rx_full     <= 1'b0;
            rx_hold     <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_en && sel.ctrl) ctrl <= PWDATA[3:0];

            if (wr_en && sel.txdata) begin
                tx_data <= PWDATA;
                tx_full <= 1'b1;
            end else if (tx_drain) begin
                tx_full <= 1'b0;
            end

            if (rx_in && (!rx_full || pop)) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (pop) begin
                rx_full <= 1'b0;
            end

            // Hardware set beats a same-cycle W1C clear.
            if (rx_in && rx_full && !pop)
                overrun <= 1'b1;
            else if (wr_en && sel.status && PWDATA[STAT_OVERRUN])
                overrun <= 1'b0;

            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (wr_en && sel.status && PWDATA[STAT_TIMEOUT])
                timeout_err <= 1'b0;
        end
    end

endmodule
